// File: rtl/svc_axi_rd_arb2.sv
// Two-master AXI4 read arbiter: a registered, arbitrated AR stage with R beats routed back by the ID MSB.
// Build with SVC_AXI_RD_ARB2_PRIO_EN for s0 strict priority with s1 starvation relief after MAX_WAIT losses.
module svc_axi_rd_arb2 #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_WAIT       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s0_axi_arvalid,
    input  logic [AXI_ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]                s0_axi_arlen,
    input  logic [2:0]                s0_axi_arsize,
    input  logic [1:0]                s0_axi_arburst,
    output logic                      s0_axi_arready,
    output logic                      s0_axi_rvalid,
    output logic [AXI_ID_WIDTH-1:0]   s0_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rlast,
    input  logic                      s0_axi_rready,

    input  logic                      s1_axi_arvalid,
    input  logic [AXI_ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]                s1_axi_arlen,
    input  logic [2:0]                s1_axi_arsize,
    input  logic [1:0]                s1_axi_arburst,
    output logic                      s1_axi_arready,
    output logic                      s1_axi_rvalid,
    output logic [AXI_ID_WIDTH-1:0]   s1_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rlast,
    input  logic                      s1_axi_rready,

    output logic                      m_axi_arvalid,
    output logic [AXI_ID_WIDTH:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic                      m_axi_arready,

    input  logic                      m_axi_rvalid,
    input  logic [AXI_ID_WIDTH:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    output logic                      m_axi_rready
);

    // Valid/ready: an AR beat transfers on a cycle where valid && ready are both high; valid never
    // waits on ready, and a raised valid with its payload holds until that transfer completes.
    logic load;
    logic any_req;
    logic gnt1;
    logic last_grant;

`ifdef SVC_AXI_RD_ARB2_PRIO_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    always_comb begin
        gnt1 = s1_axi_arvalid && (!s0_axi_arvalid || wait_cnt == WAIT_W'(MAX_WAIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!s1_axi_arvalid) begin
            wait_cnt <= '0;
        end else if (load && gnt1) begin
            wait_cnt <= '0;
        end else if (load && s0_axi_arvalid) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        gnt1 = s1_axi_arvalid && (!s0_axi_arvalid || !last_grant);
    end
`endif

    assign load           = !m_axi_arvalid || m_axi_arready;
    assign any_req        = s0_axi_arvalid || s1_axi_arvalid;
    assign s0_axi_arready = rst_n && load && s0_axi_arvalid && !gnt1;
    assign s1_axi_arready = rst_n && load && gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            last_grant    <= 1'b1;
        end else if (load) begin
            m_axi_arvalid <= any_req;
            if (any_req) begin
                m_axi_arid    <= {gnt1, gnt1 ? s1_axi_arid : s0_axi_arid};
                m_axi_araddr  <= gnt1 ? s1_axi_araddr : s0_axi_araddr;
                m_axi_arlen   <= gnt1 ? s1_axi_arlen : s0_axi_arlen;
                m_axi_arsize  <= gnt1 ? s1_axi_arsize : s0_axi_arsize;
                m_axi_arburst <= gnt1 ? s1_axi_arburst : s0_axi_arburst;
                last_grant    <= gnt1;
            end
        end
    end

    // R is stateless: the ID MSB tags which requester issued the burst.
    assign s0_axi_rvalid = m_axi_rvalid && !m_axi_rid[AXI_ID_WIDTH];
    assign s1_axi_rvalid = m_axi_rvalid && m_axi_rid[AXI_ID_WIDTH];
    assign m_axi_rready  = m_axi_rid[AXI_ID_WIDTH] ? s1_axi_rready : s0_axi_rready;

    assign s0_axi_rid   = m_axi_rid[AXI_ID_WIDTH-1:0];
    assign s1_axi_rid   = m_axi_rid[AXI_ID_WIDTH-1:0];
    assign s0_axi_rdata = m_axi_rdata;
    assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s1_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rlast = m_axi_rlast;

endmodule

// File: tb/tb_svc_axi_rd_arb2.sv
// Directed bench for svc_axi_rd_arb2: AR arbitration/stall/reset sequences plus a table of R routing vectors.
// Define SVC_AXI_RD_ARB2_PRIO_EN at compile time to check the priority build instead of round robin.
module tb_svc_axi_rd_arb2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IW = 4;
`ifdef SVC_AXI_RD_ARB2_PRIO_EN
    localparam int N_GRANT = 10;
`else
    localparam int N_GRANT = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic s0_axi_arvalid, s1_axi_arvalid;
    logic [IW-1:0] s0_axi_arid, s1_axi_arid;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr;
    logic [7:0] s0_axi_arlen, s1_axi_arlen;
    logic [2:0] s0_axi_arsize, s1_axi_arsize;
    logic [1:0] s0_axi_arburst, s1_axi_arburst;
    logic s0_axi_arready, s1_axi_arready;
    logic s0_axi_rvalid, s1_axi_rvalid;
    logic [IW-1:0] s0_axi_rid, s1_axi_rid;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0] s0_axi_rresp, s1_axi_rresp;
    logic s0_axi_rlast, s1_axi_rlast;
    logic s0_axi_rready, s1_axi_rready;
    logic m_axi_arvalid;
    logic [IW:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0] m_axi_arlen;
    logic [2:0] m_axi_arsize;
    logic [1:0] m_axi_arburst;
    logic m_axi_arready;
    logic m_axi_rvalid;
    logic [IW:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0] m_axi_rresp;
    logic m_axi_rlast;
    logic m_axi_rready;

    int checks = 0;
    int errors = 0;

    svc_axi_rd_arb2 #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr),
        .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
        .s0_axi_arready(s0_axi_arready), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rid(s0_axi_rid),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast),
        .s0_axi_rready(s0_axi_rready),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr),
        .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
        .s1_axi_arready(s1_axi_arready), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rid(s1_axi_rid),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast),
        .s1_axi_rready(s1_axi_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rvalid;
        logic [IW:0] rid;
        logic [DW-1:0] rdata;
        logic [1:0] rresp;
        logic rlast;
        logic s0_rready;
        logic s1_rready;
        logic e_s0_rvalid;
        logic e_s1_rvalid;
        logic [IW-1:0] e_rid;
        logic e_m_rready;
    } r_vec_t;

    r_vec_t r_vecs[6];

    initial begin
        logic exp_src;

        r_vecs[0] = '{1'b1, 5'h13, 16'hABCD, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0};
        r_vecs[1] = '{1'b1, 5'h13, 16'hABCD, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1};
        r_vecs[2] = '{1'b1, 5'h05, 16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 1'b1};
        r_vecs[3] = '{1'b1, 5'h05, 16'h1234, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0};
        r_vecs[4] = '{1'b0, 5'h1F, 16'h0F0F, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1};
        r_vecs[5] = '{1'b1, 5'h1A, 16'h5A5A, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1};

        rst_n = 1'b0;
        s0_axi_arvalid = 1'b1;  s1_axi_arvalid = 1'b0;
        s0_axi_arid = '0; s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arsize = '0; s0_axi_arburst = '0;
        s1_axi_arid = '0; s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arsize = '0; s1_axi_arburst = '0;
        s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
        m_axi_arready = 1'b1;
        m_axi_rvalid = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
        step(); step();
        chk("arready_in_reset", {31'd0, s0_axi_arready}, 32'd0);
        s0_axi_arvalid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("reset_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        chk("reset_s0_arready", {31'd0, s0_axi_arready}, 32'd0);
        chk("reset_s1_arready", {31'd0, s1_axi_arready}, 32'd0);

        // First single AR from s0
        s0_axi_arvalid = 1'b1; s0_axi_arid = 4'h3; s0_axi_araddr = 16'h0100;
        s0_axi_arlen = 8'd3; s0_axi_arsize = 3'd1; s0_axi_arburst = 2'd1;
        #1;
        chk("first_s0_arready", {31'd0, s0_axi_arready}, 32'd1);
        chk("first_arvalid_pre", {31'd0, m_axi_arvalid}, 32'd0);
        step();
        s0_axi_arvalid = 1'b0;
        chk("first_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
        chk("first_araddr", {16'd0, m_axi_araddr}, 32'h0100);
        chk("first_arid", {27'd0, m_axi_arid}, 32'h03);
        chk("first_arlen", {24'd0, m_axi_arlen}, 32'd3);
        chk("first_arsize", {29'd0, m_axi_arsize}, 32'd1);
        chk("first_arburst", {30'd0, m_axi_arburst}, 32'd1);
        step();
        chk("idle_arvalid", {31'd0, m_axi_arvalid}, 32'd0);

        // Both masters continuously valid after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s0_axi_arvalid = 1'b1; s0_axi_arid = 4'h1; s0_axi_araddr = 16'h1000;
        s1_axi_arvalid = 1'b1; s1_axi_arid = 4'h2; s1_axi_araddr = 16'h2000;
        s1_axi_arlen = 8'd7; s1_axi_arsize = 3'd2; s1_axi_arburst = 2'd2;
        m_axi_arready = 1'b1;
        #1;
        for (int i = 0; i < N_GRANT; i++) begin
`ifdef SVC_AXI_RD_ARB2_PRIO_EN
            exp_src = (i % 5 == 4);
`else
            exp_src = (i % 2 == 1);
`endif
            chk($sformatf("rr_s0_arready_%0d", i), {31'd0, s0_axi_arready}, {31'd0, !exp_src});
            chk($sformatf("rr_s1_arready_%0d", i), {31'd0, s1_axi_arready}, {31'd0, exp_src});
            step();
            chk($sformatf("rr_arvalid_%0d", i), {31'd0, m_axi_arvalid}, 32'd1);
            chk($sformatf("rr_arid_%0d", i), {27'd0, m_axi_arid}, exp_src ? 32'h12 : 32'h01);
            chk($sformatf("rr_araddr_%0d", i), {16'd0, m_axi_araddr}, exp_src ? 32'h2000 : 32'h1000);
        end

        // Downstream stall: last grant (s1) must hold
        m_axi_arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall_s0_arready_%0d", i), {31'd0, s0_axi_arready}, 32'd0);
            chk($sformatf("stall_s1_arready_%0d", i), {31'd0, s1_axi_arready}, 32'd0);
            step();
            chk($sformatf("stall_arvalid_%0d", i), {31'd0, m_axi_arvalid}, 32'd1);
            chk($sformatf("stall_arid_%0d", i), {27'd0, m_axi_arid}, 32'h12);
            chk($sformatf("stall_araddr_%0d", i), {16'd0, m_axi_araddr}, 32'h2000);
            chk($sformatf("stall_arlen_%0d", i), {24'd0, m_axi_arlen}, 32'd7);
        end
        m_axi_arready = 1'b1;
        #1;
        chk("release_s0_arready", {31'd0, s0_axi_arready}, 32'd1);
        step();
        chk("release_arid", {27'd0, m_axi_arid}, 32'h01);
        chk("release_araddr", {16'd0, m_axi_araddr}, 32'h1000);

        // Reset while an AR is stalled downstream
        m_axi_arready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_s0_arready", {31'd0, s0_axi_arready}, 32'd0);
        step();
        chk("rst_mid_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        rst_n = 1'b1;
        m_axi_arready = 1'b1;
        #1;
        chk("rst_mid_first_s0", {31'd0, s0_axi_arready}, 32'd1);
        chk("rst_mid_first_s1", {31'd0, s1_axi_arready}, 32'd0);
        step();
        chk("rst_mid_arid", {27'd0, m_axi_arid}, 32'h01);
        s0_axi_arvalid = 1'b0;
        s1_axi_arvalid = 1'b0;
        step();

        // R routing table
        for (int i = 0; i < 6; i++) begin
            m_axi_rvalid = r_vecs[i].rvalid;
            m_axi_rid = r_vecs[i].rid;
            m_axi_rdata = r_vecs[i].rdata;
            m_axi_rresp = r_vecs[i].rresp;
            m_axi_rlast = r_vecs[i].rlast;
            s0_axi_rready = r_vecs[i].s0_rready;
            s1_axi_rready = r_vecs[i].s1_rready;
            #1;
            chk($sformatf("r%0d_s0_rvalid", i), {31'd0, s0_axi_rvalid}, {31'd0, r_vecs[i].e_s0_rvalid});
            chk($sformatf("r%0d_s1_rvalid", i), {31'd0, s1_axi_rvalid}, {31'd0, r_vecs[i].e_s1_rvalid});
            chk($sformatf("r%0d_s0_rid", i), {28'd0, s0_axi_rid}, {28'd0, r_vecs[i].e_rid});
            chk($sformatf("r%0d_s1_rid", i), {28'd0, s1_axi_rid}, {28'd0, r_vecs[i].e_rid});
            chk($sformatf("r%0d_m_rready", i), {31'd0, m_axi_rready}, {31'd0, r_vecs[i].e_m_rready});
            chk($sformatf("r%0d_s0_rdata", i), {16'd0, s0_axi_rdata}, {16'd0, r_vecs[i].rdata});
            chk($sformatf("r%0d_s1_rdata", i), {16'd0, s1_axi_rdata}, {16'd0, r_vecs[i].rdata});
            chk($sformatf("r%0d_rresp", i), {28'd0, s0_axi_rresp, s1_axi_rresp},
                {28'd0, r_vecs[i].rresp, r_vecs[i].rresp});
            chk($sformatf("r%0d_rlast", i), {30'd0, s0_axi_rlast, s1_axi_rlast},
                {30'd0, r_vecs[i].rlast, r_vecs[i].rlast});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
